// File: rtl/icache_mem_pkg.sv
// icache_mem_pkg: shared constants for the icache memory-port arbiter
package icache_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int MEM_DATA_W = 40;
  localparam int N_BEATS = 8;
  localparam int STARVE_LIM = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RECV = 2'd3;
  localparam logic ID_DEMAND = 1'b0;
  localparam logic ID_PREFETCH = 1'b1;
endpackage

// File: rtl/icache_req_prio_arb.sv
// icache_req_prio_arb: demand-first two-way select with a prefetch starvation guard
module icache_req_prio_arb
  import icache_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic force1;
  assign force1 = starve_cnt == CW'(STARVE_LIMIT);
  assign gnt = {req1 & (~req0 | force1), req0 & ~(req1 & force1)};
  assign gnt_id = gnt[1] ? ID_PREFETCH : ID_DEMAND;
  always_ff @(posedge clk)
    if (rst) starve_cnt <= '0;
    else if (en & gnt[1]) starve_cnt <= '0;
    else if (en & gnt[0] & req1 & ~force1) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter: shares the icache memory port between demand misses and the prefetcher,
// issuing one block address and forwarding its tagged beats
module icache_mem_arbiter
  import icache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int MEM_DATA_WIDTH = MEM_DATA_W,
  parameter int NUM_BEATS = N_BEATS,
  parameter int STARVE_LIMIT = STARVE_LIM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_halt,
  input  logic [ADDR_WIDTH-1:0]        i_req0_addr,
  input  logic [ADDR_WIDTH-1:0]        i_req1_addr,
  input  logic                         i_req0_valid,
  input  logic                         i_req1_valid,
  output logic                         o_req0_ready,
  output logic                         o_req1_ready,
  output logic [ADDR_WIDTH-1:0]        o_mem_req_addr,
  output logic                         o_mem_req_valid,
  input  logic                         i_mem_req_ready,
  input  logic [MEM_DATA_WIDTH-1:0]    i_mem_data,
  input  logic                         i_mem_data_valid,
  output logic                         o_mem_ready,
  output logic [MEM_DATA_WIDTH-1:0]    o_rsp_data,
  output logic                         o_rsp_valid,
  output logic                         o_rsp_id,
  output logic [$clog2(NUM_BEATS)-1:0] o_rsp_beat,
  output logic                         o_rsp_last,
  output logic                         o_busy,
  output logic                         o_proto_err
);
  localparam int BW = $clog2(NUM_BEATS);
  logic [1:0] state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic id_q, rsp_valid_q, idle, accept, beat_take, last_beat, gnt_id;
  logic [BW-1:0] beat_cnt;
  logic [1:0] gnt;
  assign idle = state == S_IDLE;
  assign accept = idle & ~i_halt & |gnt;
  icache_req_prio_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk), .rst(rst), .en(accept), .req0(i_req0_valid), .req1(i_req1_valid),
    .gnt(gnt), .gnt_id(gnt_id)
  );
  assign o_req0_ready = idle & ~i_halt & gnt[0];
  assign o_req1_ready = idle & ~i_halt & gnt[1];
  // Valid is withheld during halt so memory cannot complete a handshake the FSM would miss
  assign o_mem_req_valid = (state == S_REQ) & ~i_halt;
  assign o_mem_req_addr = o_mem_req_valid ? addr_q : '0;
  assign o_mem_ready = (state == S_WAIT | state == S_RECV) & ~i_halt;
  assign beat_take = o_mem_ready & i_mem_data_valid;
  assign last_beat = &beat_cnt;
  assign o_rsp_valid = rsp_valid_q & ~i_halt;
  assign o_busy = ~idle;
  always_comb begin
    state_d = accept ? S_REQ
            : (o_mem_req_valid & i_mem_req_ready) ? S_WAIT
            : beat_take ? (last_beat ? S_IDLE : S_RECV)
            : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      addr_q <= '0;
      id_q <= 1'b0;
      beat_cnt <= '0;
      rsp_valid_q <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_id <= 1'b0;
      o_rsp_beat <= '0;
      o_rsp_last <= 1'b0;
      o_proto_err <= 1'b0;
    end else if (!i_halt) begin
      state <= state_d;
      rsp_valid_q <= beat_take;
      if (accept) begin
        addr_q <= gnt[1] ? i_req1_addr : i_req0_addr;
        id_q <= gnt_id;
      end
      if (beat_take) begin
        beat_cnt <= beat_cnt + 1'b1;
        o_rsp_data <= i_mem_data;
        o_rsp_id <= id_q;
        o_rsp_beat <= beat_cnt;
        o_rsp_last <= last_beat;
      end
      if (state == S_REQ && i_mem_data_valid) o_proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_icache_mem_arbiter.sv
// tb_icache_mem_arbiter: table-driven transactions with a response scoreboard
module tb_icache_mem_arbiter;
  logic clk = 1'b0, rst, i_halt, i_req0_valid, i_req1_valid, i_mem_req_ready, i_mem_data_valid;
  logic [15:0] i_req0_addr, i_req1_addr, o_mem_req_addr;
  logic [39:0] i_mem_data, o_rsp_data;
  logic o_req0_ready, o_req1_ready, o_mem_req_valid, o_mem_ready, o_rsp_valid, o_rsp_id;
  logic o_rsp_last, o_busy, o_proto_err;
  logic [2:0] o_rsp_beat;
  always #5 clk = ~clk;
  icache_mem_arbiter dut (
    .clk(clk), .rst(rst), .i_halt(i_halt),
    .i_req0_addr(i_req0_addr), .i_req1_addr(i_req1_addr),
    .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_data(i_mem_data),
    .i_mem_data_valid(i_mem_data_valid), .o_mem_ready(o_mem_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_beat(o_rsp_beat), .o_rsp_last(o_rsp_last), .o_busy(o_busy),
    .o_proto_err(o_proto_err)
  );
  typedef struct {
    logic v0, v1;
    logic [15:0] a0, a1;
    logic exp_id;
    int delay, gap, halt_b, rst_b;
    logic perr;
  } vec_t;
  vec_t tbl[14];
  logic [44:0] sb[$];
  int checks = 0, errors = 0, txn = 0;
  logic exp_err = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic v0, input logic v1, input logic [15:0] a0,
                              input logic [15:0] a1, input logic id, input int delay,
                              input int gap, input int hb, input int rb, input logic perr);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1; v.exp_id = id;
    v.delay = delay; v.gap = gap; v.halt_b = hb; v.rst_b = rb; v.perr = perr;
    return v;
  endfunction
  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {o_req0_ready, o_req1_ready, o_mem_req_valid, o_mem_ready, o_rsp_valid,
                         o_rsp_id, o_rsp_last, o_busy, o_proto_err}, 0);
    chk({name, "_addr"}, o_mem_req_addr, 0);
    chk({name, "_rsp"}, {o_rsp_data, o_rsp_beat}, 0);
  endtask
  task automatic run_txn(input vec_t v);
    int n = 0;
    logic [15:0] ea;
    logic [39:0] d;
    ea = v.exp_id ? v.a1 : v.a0;
    txn++;
    i_req0_valid = v.v0; i_req1_valid = v.v1; i_req0_addr = v.a0; i_req1_addr = v.a1;
    @(negedge clk);
    while (!(v.exp_id ? o_req1_ready : o_req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", {o_req1_ready, o_req0_ready}, v.exp_id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    for (int k = 0; k < v.delay; k++) begin
      i_mem_data_valid = v.perr && k == 0;
      @(negedge clk);
      chk("req_hold", {o_mem_req_valid, o_mem_ready, o_busy, o_mem_req_addr}, {3'b101, ea});
      @(posedge clk); #1;
      if (v.perr && k == 0) exp_err = 1'b1;
      i_mem_data_valid = 1'b0;
    end
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_addr", {o_mem_req_valid, o_mem_req_addr}, {1'b1, ea});
    @(posedge clk); #1;
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == v.rst_b) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        chk("mid_rst_sb", sb.size(), 0);
        @(posedge clk); #1;
        return;
      end
      if (b > 0) repeat (v.gap) begin @(posedge clk); #1; end
      d = {24'(txn), 16'(b + 1)};
      i_mem_data_valid = 1'b1;
      i_mem_data = d;
      if (b == v.halt_b) begin
        i_halt = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("halt_mem_ready", {o_mem_ready, o_busy}, 2'b01);
          @(posedge clk); #1;
        end
        i_halt = 1'b0;
      end
      @(negedge clk);
      chk("mem_ready", o_mem_ready, 1);
      sb.push_back({v.exp_id, 3'(b), b == 7, d});
      @(posedge clk); #1;
      i_mem_data_valid = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("txn_done", {sb.size() == 0, o_busy, o_proto_err}, {1'b1, 1'b0, exp_err});
    @(posedge clk); #1;
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (i_halt) chk("halt_rsp", o_rsp_valid, 0);
        if (o_rsp_valid) begin
          if (sb.size() == 0) chk("unexpected_rsp", {o_rsp_id, o_rsp_beat}, 64'hdead);
          else chk("rsp", {o_rsp_id, o_rsp_beat, o_rsp_last, o_rsp_data}, sb.pop_front());
        end
      end
      begin
        #2ms;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
      end
    join_none
    rst = 1'b1; i_halt = 1'b0; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_addr = '0; i_req1_addr = '0; i_mem_req_ready = 1'b0;
    i_mem_data_valid = 1'b0; i_mem_data = '0;
    tbl[0] = mk(1, 0, 16'h1A40, 16'h0, 0, 0, 0, -1, -1, 0);
    for (int i = 1; i <= 10; i++)
      tbl[i] = mk(1, 1, 16'h2000 + 16'(i), 16'h8000 + 16'(i), (i == 5 || i == 10), 0, 0, -1, -1, 0);
    tbl[11] = mk(1, 0, 16'h3C00, 16'h0, 0, 5, 2, -1, -1, 0);
    tbl[12] = mk(0, 1, 16'h0, 16'h4D10, 1, 0, 0, 3, -1, 0);
    tbl[13] = mk(1, 0, 16'h5E20, 16'h0, 0, 2, 1, -1, -1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (tbl[i]) run_txn(tbl[i]);
    chk("perr_sticky", o_proto_err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk_reset("perr_clear");
    @(posedge clk); #1;
    run_txn(mk(1, 0, 16'h6A00, 16'h0, 0, 0, 0, -1, 5, 0));
    run_txn(mk(0, 1, 16'h0, 16'h7B30, 1, 1, 0, -1, -1, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
